bf16_special_case_detector: RTL and testbench
=============================================

Name: bf16_special_case_detector

Overview:
- Classifies one floating-point operand (default bfloat16: 1 sign, 8 exponent, 7 fraction bits) as ±Inf, NaN (quiet/signalling) or ±Zero.
- Sits at the front of the FLOG (floating-point log) datapath and flags operands that bypass normal computation.
- Fully registered: one clock of latency, with a valid strobe alongside the flags.

Parameters:
- S_WIDTH, 1, sign field width; fixed at 1, no other value supported.
- EXP_WIDTH, 8, exponent field width.
- FRACT_WIDTH, 7, stored fraction (mantissa) width, no hidden bit.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- valid_i  input  1  operand fields valid this cycle.
- s_op_i  input  S_WIDTH  operand sign.
- exp_op_i  input  EXP_WIDTH  operand biased exponent.
- fract_op_i  input  FRACT_WIDTH  operand fraction.
- valid_o  output  1  flags below correspond to an operand accepted the previous cycle.
- isInf_o  output  1  operand is ±infinity.
- isPosInf_o  output  1  operand is +infinity.
- isNegInf_o  output  1  operand is −infinity.
- isNaN_o  output  1  operand is any NaN.
- isQNaN_o  output  1  operand is a quiet NaN.
- isSNaN_o  output  1  operand is a signalling NaN.
- isZero_o  output  1  operand is ±zero.
- isPosZero_o  output  1  operand is +0.
- isNegZero_o  output  1  operand is −0.

Behaviour:
- Combinational classification, with expMax = all exponent bits 1, expZero = all exponent bits 0, fractZero = all fraction bits 0:
  - Inf = expMax & fractZero.
  - NaN = expMax & ~fractZero.
  - QNaN = NaN & fract_op_i[FRACT_WIDTH-1].
  - SNaN = NaN & ~fract_op_i[FRACT_WIDTH-1].
  - Zero = expZero & fractZero.
  - PosInf/NegInf = Inf & ~s / Inf & s; PosZero/NegZero = Zero & ~s / Zero & s.
- NaN flags ignore the sign.
- Subnormals (exp 0, fraction ≠ 0) and normal numbers drive all nine flags to 0.
- Invariants: at most one of {Inf, NaN, Zero} high. QNaN and SNaN are mutually exclusive and their OR equals NaN. Same holds for the Pos/Neg pairs against Inf and Zero.
- Latency is exactly 1 cycle:
  - On a rising edge with rst_ni=1 and valid_i=1, the flags register the classification of the current inputs and valid_o <= 1.
  - On a rising edge with rst_ni=1 and valid_i=0, valid_o <= 0 and the flags hold their previous values.
- No back-pressure: a new operand may be accepted every cycle.
- Reset: a rising edge with rst_ni=0 clears valid_o and all nine flags to 0, regardless of valid_i. Reset wins over a simultaneous valid_i.
- Outputs are 0 from the first reset edge until the first accepted operand.
- Inputs are sampled only when valid_i=1. X on operand fields while valid_i=0 must not propagate to the outputs.
- No combinational path from any input to any output.

Test Plan:
- Reset with valid_i=1 and s=0/exp=0xFF/fract=0 held, then release → all outputs 0 during reset; on the first edge after release, valid_o=1, isInf_o=1, isPosInf_o=1, all other flags 0.
- Back-to-back valid operands: 1_11111111_0000000 then 0_00000000_0000000 then 1_00000000_0000000 → after 1 cycle each: isInf/isNegInf=1; then isZero/isPosZero=1; then isZero/isNegZero=1. No other flags set, valid_o=1 throughout.
- NaN split: 1_11111111_0111111 → isNaN=1, isSNaN=1, isQNaN=0. Then 1_11111111_1000000 → isNaN=1, isQNaN=1, isSNaN=0. Repeat with s=0 for identical flags.
- Non-special values: 0_01111111_0000000 (1.0), 0_00000000_0000001 (min subnormal) and 0_11111110_1111111 (max finite) → valid_o=1, all nine flags 0.
- Hold behaviour: accept +Inf, then drive valid_i=0 with X fields for 3 cycles → valid_o=0 and flags stay at isInf=1/isPosInf=1, no X on outputs.
- Mid-stream reset: stream valid NaN operands, assert rst_ni=0 for one edge → that edge yields all outputs 0. Normal classification resumes on the next valid edge.

Source files
------------

// File: rtl/bf16_special_case_detector.sv
// Registered special-value classifier for one floating-point operand (default bfloat16).
// Flags +/-Inf, quiet/signalling NaN and +/-zero one cycle after a valid operand.
module bf16_special_case_detector #(
  parameter int S_WIDTH     = 1,
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [S_WIDTH-1:0]     s_op_i,
  input  logic [EXP_WIDTH-1:0]   exp_op_i,
  input  logic [FRACT_WIDTH-1:0] fract_op_i,
  output logic                   valid_o,
  output logic                   isInf_o,
  output logic                   isPosInf_o,
  output logic                   isNegInf_o,
  output logic                   isNaN_o,
  output logic                   isQNaN_o,
  output logic                   isSNaN_o,
  output logic                   isZero_o,
  output logic                   isPosZero_o,
  output logic                   isNegZero_o
);

  if (S_WIDTH != 1) begin : g_bad_sign_width
    $error("bf16_special_case_detector: S_WIDTH must be 1");
  end

  logic exp_max;
  logic exp_zero;
  logic fract_zero;
  logic sign;
  logic is_inf;
  logic is_nan;
  logic is_zero;

  assign exp_max    = &exp_op_i;
  assign exp_zero   = ~|exp_op_i;
  assign fract_zero = ~|fract_op_i;
  assign sign       = s_op_i[0];

  assign is_inf  = exp_max & fract_zero;
  assign is_nan  = exp_max & ~fract_zero;
  assign is_zero = exp_zero & fract_zero;

  // Flag vector order: inf, +inf, -inf, nan, qnan, snan, zero, +0, -0
  logic [8:0] flags_next;
  logic [8:0] flags_reg;
  logic       valid_reg;

  always_comb begin
    flags_next    = '0;
    flags_next[8] = is_inf;
    flags_next[7] = is_inf & ~sign;
    flags_next[6] = is_inf & sign;
    flags_next[5] = is_nan;
    flags_next[4] = is_nan & fract_op_i[FRACT_WIDTH-1];
    flags_next[3] = is_nan & ~fract_op_i[FRACT_WIDTH-1];
    flags_next[2] = is_zero;
    flags_next[1] = is_zero & ~sign;
    flags_next[0] = is_zero & sign;
  end

  // Flags only load on accepted operands, so idle-cycle X on the fields never reaches them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      flags_reg <= '0;
    end else begin
      valid_reg <= valid_i;
      if (valid_i) begin
        flags_reg <= flags_next;
      end
    end
  end

  assign valid_o     = valid_reg;
  assign isInf_o     = flags_reg[8];
  assign isPosInf_o  = flags_reg[7];
  assign isNegInf_o  = flags_reg[6];
  assign isNaN_o     = flags_reg[5];
  assign isQNaN_o    = flags_reg[4];
  assign isSNaN_o    = flags_reg[3];
  assign isZero_o    = flags_reg[2];
  assign isPosZero_o = flags_reg[1];
  assign isNegZero_o = flags_reg[0];

endmodule

// File: tb/tb_bf16_special_case_detector.sv
// Scoreboard bench: driver queues the expected post-edge outputs from a value-level
// classifier; an independent monitor compares them one cycle later.
module tb_bf16_special_case_detector;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic [0:0] s_op_i;
  logic [7:0] exp_op_i;
  logic [6:0] fract_op_i;
  logic       valid_o;
  logic       isInf_o, isPosInf_o, isNegInf_o;
  logic       isNaN_o, isQNaN_o, isSNaN_o;
  logic       isZero_o, isPosZero_o, isNegZero_o;

  bf16_special_case_detector #(
    .S_WIDTH(1), .EXP_WIDTH(8), .FRACT_WIDTH(7)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
    .s_op_i(s_op_i), .exp_op_i(exp_op_i), .fract_op_i(fract_op_i),
    .valid_o(valid_o),
    .isInf_o(isInf_o), .isPosInf_o(isPosInf_o), .isNegInf_o(isNegInf_o),
    .isNaN_o(isNaN_o), .isQNaN_o(isQNaN_o), .isSNaN_o(isSNaN_o),
    .isZero_o(isZero_o), .isPosZero_o(isPosZero_o), .isNegZero_o(isNegZero_o)
  );

  always #5 clk_i = ~clk_i;

  // {valid, inf, +inf, -inf, nan, qnan, snan, zero, +0, -0}
  logic [9:0] exp_q[$];
  string      tag_q[$];
  logic [8:0] model_flags = '0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  bit         driver_done = 0;

  // Reference classifier working on the decoded operand value, not on bit masks.
  function automatic logic [8:0] classify(input bit s, input int unsigned e, input int unsigned f);
    logic [8:0] r;
    r = '0;
    if (e == 255 && f == 0) begin
      r[8] = 1; r[7] = (s == 0); r[6] = (s == 1);
    end else if (e == 255) begin
      r[5] = 1;
      if (f >= 64) r[4] = 1; else r[3] = 1;
    end else if (e == 0 && f == 0) begin
      r[2] = 1; r[1] = (s == 0); r[0] = (s == 1);
    end
    return r;
  endfunction

  // Drive one cycle's inputs, queue what the following edge must produce, then advance.
  task automatic apply(input bit rst, input bit v, input bit s, input int unsigned e,
                       input int unsigned f, input string tag);
    rst_ni  = rst;
    valid_i = v;
    if (v) begin
      s_op_i = s; exp_op_i = e[7:0]; fract_op_i = f[6:0];
    end else begin
      s_op_i = 'x; exp_op_i = 'x; fract_op_i = 'x;
    end
    if (!rst) model_flags = '0;
    else if (v) model_flags = classify(s, e, f);
    exp_q.push_back({rst & v, model_flags});
    tag_q.push_back(tag);
    @(negedge clk_i);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    logic [9:0] act, expv;
    string tag;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        act  = {valid_o, isInf_o, isPosInf_o, isNegInf_o, isNaN_o, isQNaN_o, isSNaN_o,
                isZero_o, isPosZero_o, isNegZero_o};
        n_compared++;
        if (act !== expv) begin
          n_mismatched++;
          $display("FAIL %s: got valid+flags=%b expected %b at %0t", tag, act, expv, $time);
        end else if (act[9]) begin
          $display("txn %0d %s: flags=%b", n_compared, tag, act[8:0]);
        end
      end else if (!driver_done && valid_o === 1'b1) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no output at %0t", $time);
      end
    end
  end

  initial begin
    int unsigned e, f, pick;
    bit s, v, r;
    // Reset with +Inf held on the inputs; reset must win.
    apply(0, 1, 0, 'hFF, 0, "reset_with_valid");
    apply(0, 1, 0, 'hFF, 0, "reset_with_valid");
    apply(1, 1, 0, 'hFF, 0, "first_pos_inf");
    // Back-to-back specials.
    apply(1, 1, 1, 'hFF, 0, "neg_inf");
    apply(1, 1, 0, 'h00, 0, "pos_zero");
    apply(1, 1, 1, 'h00, 0, "neg_zero");
    // NaN split, both signs.
    apply(1, 1, 1, 'hFF, 'h3F, "snan_neg");
    apply(1, 1, 1, 'hFF, 'h40, "qnan_neg");
    apply(1, 1, 0, 'hFF, 'h3F, "snan_pos");
    apply(1, 1, 0, 'hFF, 'h40, "qnan_pos");
    // Non-special values.
    apply(1, 1, 0, 'h7F, 0, "one");
    apply(1, 1, 0, 'h00, 1, "min_subnormal");
    apply(1, 1, 0, 'hFE, 'h7F, "max_finite");
    // Hold: accept +Inf then idle with X fields.
    apply(1, 1, 0, 'hFF, 0, "hold_load");
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, "hold_idle");
    // Mid-stream reset during NaN stream.
    apply(1, 1, 0, 'hFF, 'h55, "stream_qnan");
    apply(1, 1, 1, 'hFF, 'h01, "stream_snan");
    apply(0, 1, 1, 'hFF, 'h41, "midstream_reset");
    apply(1, 0, 0, 0, 0, "post_reset_idle");
    apply(1, 1, 1, 'hFF, 'h7F, "resume_qnan");
    // Randomized traffic biased toward the special exponents and zero fractions.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 3);
      e = (pick == 0) ? 0 : (pick == 1) ? 255 : $urandom_range(0, 255);
      f = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 127);
      s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 39) != 0);
      apply(r, v, s, e, f, "random");
    end
    apply(1, 0, 0, 0, 0, "drain");
    driver_done = 1;
    @(posedge clk_i);
    #2;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
